tlul_host_arb: RTL and testbench

- Two-host to one-device TL-UL arbiter. It lets the core LSU path (host 0) and the debug/DAP master (host 1) share a single TL-UL device port, such as the DCCM or the peripheral crossbar device side.
- It arbitrates the A channel round-robin and tracks outstanding requests in an in-order ID FIFO.
- It routes each D-channel response back to the host that issued the matching request.

---
 rtl/tlul_host_arb.sv | 207 ++++++++++++++++++++
 tb/tb_tlul_host_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_host_arb.sv
// ---------------------------------------------------------------------------
// tlul_pkg / tlul_host_arb
//
// tlul_pkg: minimal TL-UL channel structs shared by hosts and devices.
//
// tlul_host_arb: two-host to one-device TL-UL arbiter. Host 0 is the core
// LSU path, host 1 the debug/DAP master. The A channel is forwarded
// combinationally from the arbitration winner; the granted host ID is pushed
// into an in-order FIFO on every A handshake, and D responses are steered to
// the host at the FIFO head.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   tl_h0_i/o       host 0 (LSU) request / response
//   tl_h1_i/o       host 1 (DAP) request / response
//   tl_d_o/i        shared device request / response
//   grant_o         one-hot A-channel grant, 0 when no host requests
//   busy_o          high while any request is outstanding
//   err_unexp_o     sticky: a D response arrived with nothing outstanding
//
// Parameter MaxOutstanding (1..16): depth of the outstanding-ID FIFO.
//
// Optional build macro TLUL_HOST_ARB_FIXED_PRIO_EN: replaces round-robin with
// fixed priority (host 0 wins contention); the round-robin pointer is then
// not built. Lock and FIFO behaviour are the same in both builds.
//
// Handshake semantics: a beat transfers on a channel exactly in the cycle
// where valid and ready are both high at the rising clock edge. valid must
// not depend on ready; once raised, valid and payload hold until transfer.
// ---------------------------------------------------------------------------

package tlul_pkg;

    localparam logic [2:0] PutFullData   = 3'd0;
    localparam logic [2:0] Get           = 3'd4;
    localparam logic [2:0] AccessAck     = 3'd0;
    localparam logic [2:0] AccessAckData = 3'd1;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_host_arb #(
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tlul_pkg::tl_h2d_t tl_h0_i,
    output tlul_pkg::tl_d2h_t tl_h0_o,
    input  tlul_pkg::tl_h2d_t tl_h1_i,
    output tlul_pkg::tl_d2h_t tl_h1_o,
    output tlul_pkg::tl_h2d_t tl_d_o,
    input  tlul_pkg::tl_d2h_t tl_d_i,
    output logic [1:0]        grant_o,
    output logic              busy_o,
    output logic              err_unexp_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    logic [CntW-1:0]           count_q;
    logic [PtrW-1:0]           wr_ptr_q;
    logic [PtrW-1:0]           rd_ptr_q;
    logic [MaxOutstanding-1:0] id_fifo_q;   // one host-ID bit per outstanding request
    logic                      lock_q;
    logic                      lock_host_q;
    logic                      err_q;

    logic fifo_full;
    logic fifo_empty;
    logic head_host;
    logic pick_h1;       // contention winner: 1 selects host 1
    logic win_host;
    logic win_valid;
    logic a_hs;
    logic d_hs;
    logic head_d_ready;
    tlul_pkg::tl_h2d_t win_req;

    assign fifo_full  = (count_q == CntMax);
    assign fifo_empty = (count_q == '0);
    assign head_host  = id_fifo_q[rd_ptr_q];

`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
    assign pick_h1 = 1'b0;
`else
    // Host that won the most recent A handshake; reset to 1 so host 0 has
    // priority on the first contention.
    logic last_q;

    assign pick_h1 = ~last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b1;
        end else if (a_hs) begin
            last_q <= win_host;
        end
    end
`endif

    // Arbitration. While locked, the grant stays on the host whose beat is
    // still waiting so the device sees a stable request.
    always_comb begin
        win_host  = 1'b0;
        win_valid = 1'b0;
        if (lock_q) begin
            win_host  = lock_host_q;
            win_valid = lock_host_q ? tl_h1_i.a_valid : tl_h0_i.a_valid;
        end else if (tl_h0_i.a_valid && tl_h1_i.a_valid) begin
            win_host  = pick_h1;
            win_valid = 1'b1;
        end else if (tl_h0_i.a_valid) begin
            win_host  = 1'b0;
            win_valid = 1'b1;
        end else if (tl_h1_i.a_valid) begin
            win_host  = 1'b1;
            win_valid = 1'b1;
        end
    end

    assign grant_o = !win_valid ? 2'b00 : (win_host ? 2'b10 : 2'b01);
    assign win_req = win_host ? tl_h1_i : tl_h0_i;

    // A full FIFO blocks new requests outright; a pop in the same cycle only
    // frees the slot for the following cycle.
    assign a_hs = win_valid && !fifo_full && tl_d_i.a_ready;

    assign head_d_ready = head_host ? tl_h1_i.d_ready : tl_h0_i.d_ready;
    assign d_hs         = tl_d_i.d_valid && !fifo_empty && head_d_ready;

    always_comb begin
        tl_d_o         = win_req;
        tl_d_o.a_valid = win_valid && !fifo_full;
        // With nothing outstanding, any response is unexpected and is sunk.
        tl_d_o.d_ready = fifo_empty ? tl_d_i.d_valid : head_d_ready;
    end

    always_comb begin
        tl_h0_o         = tl_d_i;
        tl_h0_o.d_valid = tl_d_i.d_valid && !fifo_empty && !head_host;
        tl_h0_o.a_ready = grant_o[0] && !fifo_full && tl_d_i.a_ready;
        tl_h1_o         = tl_d_i;
        tl_h1_o.d_valid = tl_d_i.d_valid && !fifo_empty && head_host;
        tl_h1_o.a_ready = grant_o[1] && !fifo_full && tl_d_i.a_ready;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            id_fifo_q   <= '0;
            lock_q      <= 1'b0;
            lock_host_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (a_hs) begin
                id_fifo_q[wr_ptr_q] <= win_host;
                wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
            end
            if (d_hs) begin
                rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({a_hs, d_hs})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A presented beat that did not transfer pins the grant.
            lock_q      <= win_valid && !a_hs;
            lock_host_q <= win_host;
            if (fifo_empty && tl_d_i.d_valid) begin
                err_q <= 1'b1;
            end
        end
    end

    assign busy_o      = (count_q != '0);
    assign err_unexp_o = err_q;

endmodule

// File: tb/tb_tlul_host_arb.sv
// ---------------------------------------------------------------------------
// tb_tlul_host_arb: self-checking bench for tlul_host_arb. A per-cycle
// reference model (outstanding-ID queue, last-winner, lock and error flags)
// predicts every output; directed scenarios add literal expectations.
// ---------------------------------------------------------------------------
module tb_tlul_host_arb;
    import tlul_pkg::*;

    localparam int MAX_OUT = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tl_h2d_t    h0, h1, d_o;
    tl_d2h_t    h0_o, h1_o, dev;
    logic [1:0] grant;
    logic       busy, err;

    tlul_host_arb #(.MaxOutstanding(MAX_OUT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .tl_h0_i     (h0),
        .tl_h0_o     (h0_o),
        .tl_h1_i     (h1),
        .tl_h1_o     (h1_o),
        .tl_d_o      (d_o),
        .tl_d_i      (dev),
        .grant_o     (grant),
        .busy_o      (busy),
        .err_unexp_o (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic exp_q[$];      // host IDs of outstanding requests, oldest first
    bit   m_last;        // most recent A winner
    bit   m_lock, m_lock_host, m_err;
    bit   f_ahs, f_dhs, f_unexp, f_win, f_win_valid;

    // Compare process: predict from inputs and model state, check outputs.
    always @(negedge clk) begin : compare
        bit w, wv, full, head, hrdy;
        logic [1:0] eg;
        if (!rst_n) begin
            f_ahs = 0; f_dhs = 0; f_unexp = 0; f_win = 0; f_win_valid = 0;
        end else begin
            w = 0; wv = 0;
            if (m_lock) begin
                w  = m_lock_host;
                wv = w ? h1.a_valid : h0.a_valid;
            end else if (h0.a_valid && h1.a_valid) begin
                wv = 1;
`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
                w = 0;
`else
                w = !m_last;
`endif
            end else if (h0.a_valid) begin
                wv = 1; w = 0;
            end else if (h1.a_valid) begin
                wv = 1; w = 1;
            end
            full = (exp_q.size() == MAX_OUT);
            eg = !wv ? 2'b00 : (w ? 2'b10 : 2'b01);
            chk("grant", grant, eg);
            chk("dev_a_valid", d_o.a_valid, wv && !full);
            if (wv && !full) begin
                chk("dev_a_source", d_o.a_source, w ? h1.a_source : h0.a_source);
                chk("dev_a_address", d_o.a_address, w ? h1.a_address : h0.a_address);
            end
            chk("h0_a_ready", h0_o.a_ready, wv && !w && !full && dev.a_ready);
            chk("h1_a_ready", h1_o.a_ready, wv && w && !full && dev.a_ready);
            if (exp_q.size() > 0) begin
                head = exp_q[0];
                hrdy = head ? h1.d_ready : h0.d_ready;
                chk("h0_d_valid", h0_o.d_valid, dev.d_valid && !head);
                chk("h1_d_valid", h1_o.d_valid, dev.d_valid && head);
                chk("dev_d_ready", d_o.d_ready, hrdy);
                if (dev.d_valid)
                    chk("head_d_source", head ? h1_o.d_source : h0_o.d_source, dev.d_source);
                f_dhs = dev.d_valid && hrdy;
                f_unexp = 0;
            end else begin
                chk("h0_d_valid_idle", h0_o.d_valid, 0);
                chk("h1_d_valid_idle", h1_o.d_valid, 0);
                chk("dev_d_ready_idle", d_o.d_ready, dev.d_valid);
                f_dhs = 0;
                f_unexp = dev.d_valid;
            end
            chk("busy", busy, exp_q.size() != 0);
            chk("err_unexp", err, m_err);
            f_ahs = wv && !full && dev.a_ready;
            f_win = w;
            f_win_valid = wv;
        end
    end

    // Model state update on the clock edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_last = 1; m_lock = 0; m_lock_host = 0; m_err = 0;
        end else begin
            if (f_dhs) void'(exp_q.pop_front());
            if (f_ahs) begin
                exp_q.push_back(f_win);
                m_last = f_win;
            end
            m_lock = f_win_valid && !f_ahs;
            m_lock_host = f_win;
            if (f_unexp) m_err = 1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        h0 = '0; h1 = '0; dev = '0;
        h0.d_ready = 1'b1;
        h1.d_ready = 1'b1;
    endtask

    function automatic tl_h2d_t get_req(input logic [31:0] addr, input logic [7:0] src);
        tl_h2d_t r;
        r = '0;
        r.a_valid   = 1'b1;
        r.a_opcode  = Get;
        r.a_size    = 2'd2;
        r.a_mask    = 4'hf;
        r.a_source  = src;
        r.a_address = addr;
        r.d_ready   = 1'b1;
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_dev_a_valid", d_o.a_valid, 0);
        chk("rst_dev_d_ready", d_o.d_ready, 0);
        chk("rst_a_ready", {h0_o.a_ready, h1_o.a_ready}, 2'b00);
        chk("rst_d_valid", {h0_o.d_valid, h1_o.d_valid}, 2'b00);
        cyc(); cyc();
        rst_n = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    logic [1:0] g_seq[4];
    logic [1:0] g_exp[4];
    logic       route_exp[4];

    initial begin : watchdog
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : main
        idle_inputs();
        #3;
        do_reset();

        // Single host Get; device responds next cycle.
        cyc();
        h0 = get_req(32'h1000_0000, 8'h05);
        dev.a_ready = 1'b1;
        @(negedge clk);
        chk("single_grant", grant, 2'b01);
        chk("single_addr", d_o.a_address, 32'h1000_0000);
        cyc();
        h0.a_valid = 1'b0;
        dev.d_valid = 1'b1; dev.d_opcode = AccessAckData;
        dev.d_source = 8'h05; dev.d_data = 32'hcafe_f00d;
        @(negedge clk);
        chk("single_h0_dvalid", h0_o.d_valid, 1);
        chk("single_h0_dsrc", h0_o.d_source, 8'h05);
        chk("single_h1_dvalid", h1_o.d_valid, 0);
        chk("single_busy1", busy, 1);
        cyc();
        dev.d_valid = 1'b0;
        @(negedge clk);
        chk("single_busy0", busy, 0);

        // Contention: both request every cycle, device always ready.
        do_reset();
        cyc();
        h0 = get_req(32'h0000_0100, 8'h01);
        h1 = get_req(32'h0000_0200, 8'h02);
        dev.a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                dev.d_valid = 1'b1; dev.d_opcode = AccessAckData; dev.d_source = 8'h33;
            end
            @(negedge clk);
            g_seq[i] = grant;
            cyc();
        end
        h0.a_valid = 1'b0; h1.a_valid = 1'b0;
        cyc();
        dev.d_valid = 1'b0;
        @(negedge clk);
        chk("contend_busy0", busy, 0);
`ifdef TLUL_HOST_ARB_FIXED_PRIO_EN
        g_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        g_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        for (int i = 0; i < 4; i++) chk($sformatf("contend_grant%0d", i), g_seq[i], g_exp[i]);

        // Lock: h1 waits 3 cycles on a_ready while h0 joins.
        do_reset();
        cyc();
        h1 = get_req(32'h2000_0000, 8'h11);
        dev.a_ready = 1'b0;
        @(negedge clk); chk("lock_grant_c1", grant, 2'b10);
        cyc();
        h0 = get_req(32'h2000_0004, 8'h22);
        @(negedge clk); chk("lock_grant_c2", grant, 2'b10);
        cyc();
        @(negedge clk); chk("lock_grant_c3", grant, 2'b10);
        cyc();
        dev.a_ready = 1'b1;
        @(negedge clk);
        chk("lock_grant_hs", grant, 2'b10);
        chk("lock_h1_ready", h1_o.a_ready, 1);
        chk("lock_h0_ready", h0_o.a_ready, 0);
        cyc();
        h1.a_valid = 1'b0;
        @(negedge clk); chk("lock_h0_next", grant, 2'b01);
        cyc();
        h0.a_valid = 1'b0;
        dev.d_valid = 1'b1; dev.d_source = 8'h11;
        @(negedge clk); chk("lock_rsp_h1", {h1_o.d_valid, h0_o.d_valid}, 2'b10);
        cyc();
        dev.d_source = 8'h22;
        @(negedge clk); chk("lock_rsp_h0", {h1_o.d_valid, h0_o.d_valid}, 2'b01);
        cyc();
        dev.d_valid = 1'b0;

        // FIFO full: 4 accepted, 5th blocked until a D handshake frees a slot.
        do_reset();
        cyc();
        dev.a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            h0 = get_req(32'h3000_0000 + 32'(i * 4), 8'(i));
            cyc();
        end
        h0 = get_req(32'h3000_0010, 8'h04);
        @(negedge clk);
        chk("full_h0_ready", h0_o.a_ready, 0);
        chk("full_dev_a_valid", d_o.a_valid, 0);
        chk("full_busy", busy, 1);
        cyc();
        dev.d_valid = 1'b1; dev.d_source = 8'h00;
        @(negedge clk);
        chk("full_pop_ready", h0_o.a_ready, 0);
        chk("full_pop_dvalid", h0_o.d_valid, 1);
        cyc();
        dev.d_valid = 1'b0;
        @(negedge clk); chk("full_after_pop_ready", h0_o.a_ready, 1);
        cyc();
        h0.a_valid = 1'b0;
        dev.d_valid = 1'b1;
        for (int i = 1; i < 5; i++) begin
            dev.d_source = 8'(i);
            cyc();
        end
        dev.d_valid = 1'b0;
        @(negedge clk); chk("full_drained", busy, 0);

        // Interleaved routing: h0,h1,h1,h0 in order.
        do_reset();
        cyc();
        dev.a_ready = 1'b1;
        h0 = get_req(32'h4000_0000, 8'h40); cyc();
        h0.a_valid = 1'b0;
        h1 = get_req(32'h4000_0004, 8'h41); cyc();
        h1 = get_req(32'h4000_0008, 8'h42); cyc();
        h1.a_valid = 1'b0;
        h0 = get_req(32'h4000_000c, 8'h43); cyc();
        h0.a_valid = 1'b0;
        route_exp = '{1'b0, 1'b1, 1'b1, 1'b0};
        dev.d_valid = 1'b1; dev.d_opcode = AccessAckData;
        for (int i = 0; i < 4; i++) begin
            dev.d_source = 8'(8'h40 + i);
            @(negedge clk);
            chk($sformatf("route%0d", i), {h1_o.d_valid, h0_o.d_valid},
                route_exp[i] ? 2'b10 : 2'b01);
            cyc();
        end
        dev.d_valid = 1'b0;
        @(negedge clk); chk("route_busy0", busy, 0);

        // Unexpected response, then async reset mid-transaction.
        cyc();
        dev.d_valid = 1'b1; dev.d_source = 8'h77;
        @(negedge clk);
        chk("unexp_d_ready", d_o.d_ready, 1);
        chk("unexp_no_dvalid", {h1_o.d_valid, h0_o.d_valid}, 2'b00);
        cyc();
        dev.d_valid = 1'b0;
        @(negedge clk); chk("unexp_err_set", err, 1);
        cyc();
        @(negedge clk); chk("unexp_err_held", err, 1);
        cyc();
        h0 = get_req(32'h5000_0000, 8'h50);
        cyc();
        h0.a_valid = 1'b0;
        @(negedge clk);
        chk("midrst_busy_before", busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_err", err, 0);
        chk("midrst_busy", busy, 0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
